// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the region decode enum, the MMIO register offsets and the byte-merge helper.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_ERR
   } region_e;

   localparam logic [11:0] OFF_LED   = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h004;
   localparam logic [11:0] OFF_ID    = 12'h008;

   localparam logic [31:0] MMIO_ID   = 32'h4D49_5053;

   // Replace the byte lanes selected by be with the matching lanes of nw.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] nw,
                                                input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port word RAM with per-byte write enables and registered read.
// The read register has no reset and no enable other than a read access, so it maps onto block RAM.
module dmem_bram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // be == 0 is a read; otherwise update only the selected lanes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (be == 4'b0000) begin
            rdata <= mem[addr];
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: RAM, LED/timer/ID register window, and an error region.
// Responses appear one cycle after the request edge; rdata holds between responses.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'h1FFF_F000,
   parameter int unsigned LED_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [3:0]       be,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic             addr_err,
   output logic [LED_W-1:0] led,
   output logic [31:0]      timer
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

   region_e     region_c;
   region_e     rsel;
   logic        take_c;
   logic        is_write_c;
   logic        ram_en_c;
   logic        mmio_wr_c;
   logic [9:0]  moff_c;
   logic [31:0] mmio_rd_c;
   logic [31:0] mmio_q;
   logic [31:0] ram_q;

   // Region decode; RAM takes priority should the window ever overlap it.
   always_comb begin
      region_c = REG_ERR;
      if (addr < RAM_BYTES) begin
         region_c = REG_RAM;
      end else if (addr[31:12] == MMIO_BASE[31:12]) begin
         region_c = REG_MMIO;
      end
   end

   // Requests seen while reset is asserted are dropped entirely.
   assign take_c     = req && rst;
   assign is_write_c = (be != 4'b0000);
   assign ram_en_c   = take_c && (region_c == REG_RAM);
   assign mmio_wr_c  = take_c && is_write_c && (region_c == REG_MMIO);
   assign moff_c     = addr[11:2];

   always_comb begin
      mmio_rd_c = 32'h0;
      if (moff_c == OFF_LED[11:2]) begin
         mmio_rd_c = 32'(led);
      end else if (moff_c == OFF_TIMER[11:2]) begin
         mmio_rd_c = timer;
      end else if (moff_c == OFF_ID[11:2]) begin
         mmio_rd_c = MMIO_ID;
      end
   end

   dmem_bram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_bram (
      .clk   (clk),
      .en    (ram_en_c),
      .be    (be),
      .addr  (addr[AW+1:2]),
      .wdata (wdata),
      .rdata (ram_q)
   );

   // Response flags, read source select and MMIO registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rvalid   <= 1'b0;
         addr_err <= 1'b0;
         rsel     <= REG_ERR;
         mmio_q   <= 32'h0;
         led      <= '0;
         timer    <= 32'h0;
      end else begin
         rvalid   <= take_c && !is_write_c;
         addr_err <= take_c && (region_c == REG_ERR);
         if (take_c && !is_write_c) begin
            rsel   <= region_c;
            mmio_q <= mmio_rd_c;
         end
         if (mmio_wr_c && (moff_c == OFF_TIMER[11:2])) begin
            timer <= merge_bytes(timer, wdata, be);
         end else begin
            timer <= timer + 32'd1;
         end
         if (mmio_wr_c && (moff_c == OFF_LED[11:2])) begin
            for (int b = 0; b < int'(LED_W); b++) begin
               if (be[b/8]) led[b] <= wdata[b];
            end
         end
      end
   end

   // Error reads and the post-reset state both present zero.
   always_comb begin
      rdata = 32'h0;
      case (rsel)
         REG_RAM:  rdata = ram_q;
         REG_MMIO: rdata = mmio_q;
         default:  rdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        addr_err;
   logic [15:0] led;
   logic [31:0] timer;

   int total;
   int fails;

   localparam logic [31:0] A_LED   = 32'h1FFF_F000;
   localparam logic [31:0] A_TIMER = 32'h1FFF_F004;
   localparam logic [31:0] A_ID    = 32'h1FFF_F008;
   localparam logic [31:0] A_OTHER = 32'h1FFF_F010;
   localparam logic [31:0] A_ERR   = 32'h0800_0000;

   dmem_responder #(
      .DEPTH_WORDS(1024),
      .MMIO_BASE  (32'h1FFF_F000),
      .LED_W      (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .be       (be),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .addr_err (addr_err),
      .led      (led),
      .timer    (timer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
      req   = r;
      be    = b;
      addr  = a;
      wdata = d;
   endtask

   task automatic idle();
      drive(1'b0, 4'b0000, 32'h0, 32'h0);
   endtask

   initial begin
      total = 0;
      fails = 0;
      rst   = 1'b0;
      idle();

      // Reset state
      tick();
      tick();
      check("rst_rdata", rdata, 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_addr_err", 32'(addr_err), 32'h0);
      check("rst_led", 32'(led), 32'h0);
      check("rst_timer", timer, 32'h0);

      // ID read right after reset release; timer counts from 0
      rst = 1'b1;
      drive(1'b1, 4'b0000, A_ID, 32'h0);
      tick();
      check("id_rvalid", 32'(rvalid), 32'h1);
      check("id_rdata", rdata, 32'h4D49_5053);
      check("id_timer", timer, 32'h1);
      idle();
      tick();
      check("idle_rvalid", 32'(rvalid), 32'h0);
      check("idle_rdata_hold", rdata, 32'h4D49_5053);
      check("idle_timer", timer, 32'h2);

      // Byte lanes
      drive(1'b1, 4'b1111, 32'h10, 32'hAABB_CCDD);
      tick();
      check("wr_rvalid", 32'(rvalid), 32'h0);
      drive(1'b1, 4'b0100, 32'h10, 32'h0011_2233);
      tick();
      drive(1'b1, 4'b0000, 32'h10, 32'h0);
      tick();
      check("lane_rvalid", 32'(rvalid), 32'h1);
      check("lane_rdata", rdata, 32'hAA11_CCDD);

      // Back-to-back reads
      drive(1'b1, 4'b1111, 32'h0, 32'd1);
      tick();
      drive(1'b1, 4'b1111, 32'h4, 32'd2);
      tick();
      drive(1'b1, 4'b1111, 32'h8, 32'd3);
      tick();
      drive(1'b1, 4'b0000, 32'h0, 32'h0);
      tick();
      check("b2b0_rvalid", 32'(rvalid), 32'h1);
      check("b2b0_rdata", rdata, 32'd1);
      drive(1'b1, 4'b0000, 32'h4, 32'h0);
      tick();
      check("b2b1_rvalid", 32'(rvalid), 32'h1);
      check("b2b1_rdata", rdata, 32'd2);
      drive(1'b1, 4'b0000, 32'h8, 32'h0);
      tick();
      check("b2b2_rvalid", 32'(rvalid), 32'h1);
      check("b2b2_rdata", rdata, 32'd3);
      idle();
      tick();
      check("b2b_end_rvalid", 32'(rvalid), 32'h0);
      check("b2b_end_hold", rdata, 32'd3);

      // Last RAM word and first address past RAM
      drive(1'b1, 4'b1111, 32'hFFC, 32'hCAFE_F00D);
      tick();
      drive(1'b1, 4'b0000, 32'hFFC, 32'h0);
      tick();
      check("last_word", rdata, 32'hCAFE_F00D);
      check("last_word_err", 32'(addr_err), 32'h0);
      drive(1'b1, 4'b0000, 32'h1000, 32'h0);
      tick();
      check("past_ram_err", 32'(addr_err), 32'h1);
      check("past_ram_rdata", rdata, 32'h0);

      // Timer load and wrap
      drive(1'b1, 4'b1111, A_TIMER, 32'hFFFF_FFFE);
      tick();
      check("tmr_load", timer, 32'hFFFF_FFFE);
      idle();
      tick();
      check("tmr_max", timer, 32'hFFFF_FFFF);
      tick();
      check("tmr_wrap", timer, 32'h0);
      tick();
      drive(1'b1, 4'b0000, A_TIMER, 32'h0);
      tick();
      check("tmr_read_pre", rdata, 32'h1);
      check("tmr_after_read", timer, 32'h2);
      drive(1'b1, 4'b1111, A_TIMER, 32'h1234_5678);
      tick();
      drive(1'b1, 4'b0001, A_TIMER, 32'h0000_00AA);
      tick();
      check("tmr_partial", timer, 32'h1234_56AA);
      idle();
      tick();
      check("tmr_partial_inc", timer, 32'h1234_56AB);

      // LED register, ID write ignored, unmapped offset
      drive(1'b1, 4'b1111, A_LED, 32'hDEAD_BEEF);
      tick();
      check("led_full", 32'(led), 32'h0000_BEEF);
      drive(1'b1, 4'b0000, A_LED, 32'h0);
      tick();
      check("led_read", rdata, 32'h0000_BEEF);
      drive(1'b1, 4'b0010, A_LED, 32'h0000_1200);
      tick();
      check("led_partial", 32'(led), 32'h0000_12EF);
      drive(1'b1, 4'b1111, A_ID, 32'h0);
      tick();
      check("id_wr_err", 32'(addr_err), 32'h0);
      drive(1'b1, 4'b0000, A_ID, 32'h0);
      tick();
      check("id_ro", rdata, 32'h4D49_5053);
      drive(1'b1, 4'b0000, A_OTHER, 32'h0);
      tick();
      check("other_rdata", rdata, 32'h0);
      check("other_err", 32'(addr_err), 32'h0);
      check("other_rvalid", 32'(rvalid), 32'h1);

      // Error region
      drive(1'b1, 4'b0000, A_ERR, 32'h0);
      tick();
      check("err_rd_flag", 32'(addr_err), 32'h1);
      check("err_rd_rvalid", 32'(rvalid), 32'h1);
      check("err_rd_rdata", rdata, 32'h0);
      drive(1'b1, 4'b1111, A_ERR, 32'hFFFF_FFFF);
      tick();
      check("err_wr_flag", 32'(addr_err), 32'h1);
      check("err_wr_rvalid", 32'(rvalid), 32'h0);
      drive(1'b1, 4'b0000, 32'h0, 32'h0);
      tick();
      check("err_wr_ram0", rdata, 32'd1);
      check("err_wr_led", 32'(led), 32'h0000_12EF);
      check("err_clear", 32'(addr_err), 32'h0);

      // Reset mid-operation drops the concurrent write
      drive(1'b1, 4'b1111, 32'h20, 32'h0000_0077);
      tick();
      rst = 1'b0;
      drive(1'b1, 4'b1111, 32'h20, 32'd5);
      tick();
      check("mid_rst_led", 32'(led), 32'h0);
      check("mid_rst_timer", timer, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_rvalid", 32'(rvalid), 32'h0);
      rst = 1'b1;
      drive(1'b1, 4'b0000, 32'h20, 32'h0);
      tick();
      check("mid_rst_ram", rdata, 32'h0000_0077);
      check("mid_rst_rvalid2", 32'(rvalid), 32'h1);
      idle();
      tick();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
